// File: rtl/z80_bus_arbiter_if.sv
// Bundles the core-side, DMA-side and RAM-side signals of the z80 RAM arbiter.
// Latency: wires only, no state.
// Backpressure: none here; DMA_REQ/DMA_ACK and HOLD carry all flow control.
//
// Groups: core (CPU_A/CPU_DO/CPU_W in, CPU_DI/HOLD out), DMA requester
// (DMA_REQ/WE/ADDR/WDATA in, DMA_ACK/RDATA/VALID out) and the synchronous RAM
// port (MEM_A/MEM_D/MEM_W out, MEM_Q in). "master" is the arbiter's view,
// "slave" is the view of the environment (core, DMA engine and RAM).
interface z80_bus_arbiter_if;
    logic [15:0] CPU_A;
    logic [7:0]  CPU_DO;
    logic        CPU_W;
    logic [7:0]  CPU_DI;
    logic        HOLD;
    logic        DMA_REQ;
    logic        DMA_WE;
    logic [15:0] DMA_ADDR;
    logic [7:0]  DMA_WDATA;
    logic        DMA_ACK;
    logic [7:0]  DMA_RDATA;
    logic        DMA_VALID;
    logic [15:0] MEM_A;
    logic [7:0]  MEM_D;
    logic        MEM_W;
    logic [7:0]  MEM_Q;

    modport master (
        input  CPU_A, CPU_DO, CPU_W, DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, MEM_Q,
        output CPU_DI, HOLD, DMA_ACK, DMA_RDATA, DMA_VALID, MEM_A, MEM_D, MEM_W
    );

    modport slave (
        output CPU_A, CPU_DO, CPU_W, DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, MEM_Q,
        input  CPU_DI, HOLD, DMA_ACK, DMA_RDATA, DMA_VALID, MEM_A, MEM_D, MEM_W
    );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Shares one synchronous RAM port between the z80 core and a DMA requester.
// Latency: grant 1 cycle after an eligible request; core resumes 2 cycles after the last accept.
// Backpressure: core is frozen via HOLD=0; DMA is paced by combinational DMA_ACK.
//
// Ports: CLOCK (rising edge), RESET (synchronous, active high), bus
// (z80_bus_arbiter_if.master). States: CPU owns the RAM, DMA owns the RAM
// for up to MAX_BURST accepts, RESUME re-fetches the core's frozen address
// so that MEM_Q holds the core's data on the cycle HOLD rises again.
module z80_bus_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CPU_MIN   = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    z80_bus_arbiter_if.master bus
);
    localparam int WMIN = (CPU_MIN < 1) ? 1 : CPU_MIN;
    localparam int WW   = $clog2(WMIN + 1);
    localparam int BW   = $clog2(MAX_BURST + 1);

    localparam logic [WW-1:0] WCNT_SAT  = WW'(WMIN);
    localparam logic [WW-1:0] WCNT_ELIG = WW'(WMIN - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_DMA    = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic          dma_ack;
    logic          dma_valid;
    logic          win_ok;
    logic          burst_last;

    // wcnt counts CPU cycles already completed in this window, so the current
    // cycle is number wcnt+1; the window is open from cycle WMIN onwards.
    always_comb begin
        dma_ack    = (state == ST_DMA) && bus.DMA_REQ && !RESET;
        win_ok     = (wcnt >= WCNT_ELIG);
        burst_last = dma_ack && (bcnt == BCNT_LAST);
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        bcnt_nxt   = bcnt;
        case (state)
            ST_CPU: begin
                if (wcnt != WCNT_SAT) begin
                    wcnt_nxt = wcnt + 1'b1;
                end
                if (bus.DMA_REQ && win_ok) begin
                    state_nxt = ST_DMA;
                    bcnt_nxt  = '0;
                end
            end
            ST_DMA: begin
                if (dma_ack) begin
                    bcnt_nxt = bcnt + 1'b1;
                end
                if (!bus.DMA_REQ || burst_last) begin
                    state_nxt = ST_RESUME;
                end
            end
            ST_RESUME: begin
                state_nxt = ST_CPU;
                wcnt_nxt  = '0;
            end
            default: begin
                state_nxt = ST_RESUME;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= ST_RESUME;
            wcnt      <= '0;
            bcnt      <= '0;
            dma_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            bcnt      <= bcnt_nxt;
            dma_valid <= dma_ack && !bus.DMA_WE;
        end
    end

    // RAM port mux. RESUME presents the core address with the write gated off,
    // so a write the core is holding while frozen lands in the next CPU cycle.
    // RESET suppresses writes in whatever state the arbiter was caught in.
    always_comb begin
        bus.MEM_A = bus.CPU_A;
        bus.MEM_D = bus.CPU_DO;
        bus.MEM_W = 1'b0;
        case (state)
            ST_CPU: begin
                bus.MEM_W = bus.CPU_W && !RESET;
            end
            ST_DMA: begin
                bus.MEM_A = bus.DMA_ADDR;
                bus.MEM_D = bus.DMA_WDATA;
                bus.MEM_W = dma_ack && bus.DMA_WE;
            end
            default: begin
                bus.MEM_W = 1'b0;
            end
        endcase
    end

    // HOLD decodes the state register directly, so it is glitch-free.
    assign bus.HOLD      = (state == ST_CPU);
    assign bus.DMA_ACK   = dma_ack;
    assign bus.DMA_VALID = dma_valid;
    assign bus.CPU_DI    = bus.MEM_Q;
    assign bus.DMA_RDATA = bus.MEM_Q;
endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter with a registered 64 KiB RAM model.
// Latency: n/a.
// Backpressure: n/a; the bench scripts the core freeze and DMA handshakes.
module tb_z80_bus_arbiter;
    logic CLOCK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_bad = 0;

    z80_bus_arbiter_if bus ();

    z80_bus_arbiter #(.MAX_BURST(16), .CPU_MIN(4)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    // Registered RAM: read-before-write, MEM_Q(n+1) = mem[MEM_A(n)].
    logic [7:0] mem [0:65535];
    always @(posedge CLOCK) begin
        if (bus.MEM_W) mem[bus.MEM_A] <= bus.MEM_D;
        bus.MEM_Q <= mem[bus.MEM_A];
    end

    typedef struct {
        logic        rst, req, we;
        logic [15:0] daddr;
        logic [7:0]  wd;
        logic [15:0] ca;
        logic        cw;
        logic [7:0]  cdo;
        bit          chk;
        logic        h, a, v, mw;
        bit          cka;
        logic [15:0] ma;
        bit          ckq;
        logic [7:0]  q;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, req, we, input logic [15:0] daddr, input logic [7:0] wd,
                       input logic [15:0] ca, input logic cw, input logic [7:0] cdo,
                       input bit chk, input logic h, a, v, mw,
                       input bit cka, input logic [15:0] ma, input bit ckq, input logic [7:0] q);
        vec_t e;
        e.rst = rst; e.req = req; e.we = we; e.daddr = daddr; e.wd = wd;
        e.ca = ca; e.cw = cw; e.cdo = cdo; e.chk = chk;
        e.h = h; e.a = a; e.v = v; e.mw = mw;
        e.cka = cka; e.ma = ma; e.ckq = ckq; e.q = q;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic rst, req, we, input logic [15:0] daddr, input logic [7:0] wd,
                         input logic [15:0] ca, input logic cw, input logic [7:0] cdo);
        @(negedge CLOCK);
        RESET         = rst;
        bus.DMA_REQ   = req;
        bus.DMA_WE    = we;
        bus.DMA_ADDR  = daddr;
        bus.DMA_WDATA = wd;
        bus.CPU_A     = ca;
        bus.CPU_W     = cw;
        bus.CPU_DO    = cdo;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0, 8'h0, 16'h0F00, 0, 8'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacks;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h4000] = 8'h11;
        mem[16'h4001] = 8'h22;
        mem[16'h4002] = 8'h33;
        mem[16'h1011] = 8'h6B;
        mem[16'h0100] = 8'h3E;

        // Reset, 10 idle CPU cycles (one core write), a 3-read burst, resume.
        //   rst req we daddr   wd     ca       cw cdo    chk h a v mw cka ma       ckq q
        add(1, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 8'h00, 0, 0,0,0,0, 0, 16'h0000, 0, 8'h00);
        add(1, 0, 0, 16'h0000, 8'h00, 16'h0010, 0, 8'h00, 1, 0,0,0,0, 1, 16'h0010, 0, 8'h00);
        add(0, 0, 0, 16'h0000, 8'h00, 16'h0011, 0, 8'h00, 1, 0,0,0,0, 1, 16'h0011, 0, 8'h00);
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, 16'h0000, 8'h00, 16'h1000 + 16'(i), (i == 2), 8'hA5,
                1, 1,0,0,(i == 2), 1, 16'h1000 + 16'(i), 0, 8'h00);
        add(0, 1, 0, 16'h4000, 8'h00, 16'h1010, 0, 8'h00, 1, 1,0,0,0, 1, 16'h1010, 0, 8'h00);
        add(0, 1, 0, 16'h4000, 8'h00, 16'h1011, 0, 8'h00, 1, 0,1,0,0, 1, 16'h4000, 0, 8'h00);
        add(0, 1, 0, 16'h4001, 8'h00, 16'h1011, 0, 8'h00, 1, 0,1,1,0, 1, 16'h4001, 1, 8'h11);
        add(0, 1, 0, 16'h4002, 8'h00, 16'h1011, 0, 8'h00, 1, 0,1,1,0, 1, 16'h4002, 1, 8'h22);
        add(0, 0, 0, 16'h0000, 8'h00, 16'h1011, 0, 8'h00, 1, 0,0,1,0, 0, 16'h0000, 1, 8'h33);
        add(0, 0, 0, 16'h0000, 8'h00, 16'h1011, 0, 8'h00, 1, 0,0,0,0, 1, 16'h1011, 0, 8'h00);
        add(0, 0, 0, 16'h0000, 8'h00, 16'h1011, 0, 8'h00, 1, 1,0,0,0, 1, 16'h1011, 1, 8'h6B);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].daddr, tbl[i].wd,
                  tbl[i].ca, tbl[i].cw, tbl[i].cdo);
            if (tbl[i].chk) begin
                chk($sformatf("v%0d.hold", i), bus.HOLD, tbl[i].h);
                chk($sformatf("v%0d.ack", i), bus.DMA_ACK, tbl[i].a);
                chk($sformatf("v%0d.valid", i), bus.DMA_VALID, tbl[i].v);
                chk($sformatf("v%0d.mem_w", i), bus.MEM_W, tbl[i].mw);
            end
            if (tbl[i].cka) chk($sformatf("v%0d.mem_a", i), bus.MEM_A, tbl[i].ma);
            if (tbl[i].ckq) begin
                chk($sformatf("v%0d.dma_rdata", i), bus.DMA_RDATA, tbl[i].q);
                chk($sformatf("v%0d.cpu_di", i), bus.CPU_DI, tbl[i].q);
            end
        end
        chk("core_wr_1002", mem[16'h1002], 8'hA5);

        // Continuous DMA writes: 16 acks, 1 RESUME, 4 CPU cycles, repeating.
        idle(4);
        nacks = 0;
        for (int o = 0; o <= 42; o++) begin
            logic req, e_ack, e_hold;
            int   m;
            req = (o <= 41);
            drive(0, req, 1, 16'h2000 + 16'(nacks), 8'(nacks) ^ 8'h5A, 16'h0F00, 0, 8'h00);
            m      = (o == 0) ? 20 : (o - 1) % 21;
            e_ack  = req && (m < 16);
            e_hold = (m > 16);
            chk($sformatf("cont%0d.hold", o), bus.HOLD, e_hold);
            chk($sformatf("cont%0d.ack", o), bus.DMA_ACK, e_ack);
            if (bus.DMA_ACK) begin
                chk($sformatf("cont%0d.mem_w", o), bus.MEM_W, 1'b1);
                chk($sformatf("cont%0d.mem_a", o), bus.MEM_A, 16'h2000 + 16'(nacks));
                nacks++;
            end
        end
        chk("cont.nacks", 16'(nacks), 16'd32);
        for (int i = 0; i < 32; i++)
            chk($sformatf("cont.ram%0d", i), mem[16'h2000 + 16'(i)], 8'(i) ^ 8'h5A);

        // LD (0x8000),HL: DMA request rises with the first write; the second
        // write is held by the frozen core and lands after RESUME.
        drive(0, 1, 1, 16'h3000, 8'h77, 16'h8000, 1, 8'h34);
        chk("ld.b0.hold", bus.HOLD, 1'b1);
        chk("ld.b0.ack", bus.DMA_ACK, 1'b0);
        chk("ld.b0.mem_w", bus.MEM_W, 1'b1);
        chk("ld.b0.mem_a", bus.MEM_A, 16'h8000);
        drive(0, 1, 1, 16'h3000, 8'h77, 16'h8001, 1, 8'h12);
        chk("ld.b1.hold", bus.HOLD, 1'b0);
        chk("ld.b1.ack", bus.DMA_ACK, 1'b1);
        chk("ld.b1.mem_a", bus.MEM_A, 16'h3000);
        drive(0, 1, 1, 16'h3001, 8'h78, 16'h8001, 1, 8'h12);
        chk("ld.b2.ack", bus.DMA_ACK, 1'b1);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h8001, 1, 8'h12);
        chk("ld.b3.ack", bus.DMA_ACK, 1'b0);
        chk("ld.b3.mem_w", bus.MEM_W, 1'b0);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h8001, 1, 8'h12);
        chk("ld.b4.hold", bus.HOLD, 1'b0);
        chk("ld.b4.mem_w", bus.MEM_W, 1'b0);
        chk("ld.b4.mem_a", bus.MEM_A, 16'h8001);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h8001, 1, 8'h12);
        chk("ld.b5.hold", bus.HOLD, 1'b1);
        chk("ld.b5.mem_w", bus.MEM_W, 1'b1);
        chk("ld.b5.mem_a", bus.MEM_A, 16'h8001);
        idle(4);
        chk("ld.ram8000", mem[16'h8000], 8'h34);
        chk("ld.ram8001", mem[16'h8001], 8'h12);
        chk("ld.ram3000", mem[16'h3000], 8'h77);
        chk("ld.ram3001", mem[16'h3001], 8'h78);

        // Frozen fetch at 0x0100 overwritten by DMA; re-fetch must see 0x55.
        drive(0, 1, 1, 16'h0100, 8'h55, 16'h0100, 0, 8'h00);
        chk("fetch.f0.ack", bus.DMA_ACK, 1'b0);
        drive(0, 1, 1, 16'h0100, 8'h55, 16'h0100, 0, 8'h00);
        chk("fetch.f1.ack", bus.DMA_ACK, 1'b1);
        chk("fetch.f1.mem_w", bus.MEM_W, 1'b1);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h0100, 0, 8'h00);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h0100, 0, 8'h00);
        chk("fetch.f3.hold", bus.HOLD, 1'b0);
        chk("fetch.f3.mem_a", bus.MEM_A, 16'h0100);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h0100, 0, 8'h00);
        chk("fetch.f4.hold", bus.HOLD, 1'b1);
        chk("fetch.f4.cpu_di", bus.CPU_DI, 8'h55);

        // Reset on the 2nd cycle of a write burst, then the normal recovery and
        // a request that must wait for the 4th CPU cycle of the new window.
        idle(4);
        drive(0, 1, 1, 16'h5000, 8'hE1, 16'h0200, 0, 8'h00);
        chk("rst.d0.ack", bus.DMA_ACK, 1'b0);
        drive(0, 1, 1, 16'h5000, 8'hE1, 16'h0200, 0, 8'h00);
        chk("rst.d1.ack", bus.DMA_ACK, 1'b1);
        chk("rst.d1.mem_w", bus.MEM_W, 1'b1);
        drive(1, 1, 1, 16'h5001, 8'hE2, 16'h0200, 0, 8'h00);
        chk("rst.d2.ack", bus.DMA_ACK, 1'b0);
        chk("rst.d2.mem_w", bus.MEM_W, 1'b0);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h0200, 0, 8'h00);
        chk("rst.d3.hold", bus.HOLD, 1'b0);
        chk("rst.d3.ack", bus.DMA_ACK, 1'b0);
        chk("rst.d3.valid", bus.DMA_VALID, 1'b0);
        chk("rst.d3.mem_w", bus.MEM_W, 1'b0);
        for (int i = 4; i <= 7; i++) begin
            drive(0, 1, 0, 16'h4000, 8'h00, 16'h0200, 0, 8'h00);
            chk($sformatf("rst.d%0d.hold", i), bus.HOLD, 1'b1);
            chk($sformatf("rst.d%0d.ack", i), bus.DMA_ACK, 1'b0);
            chk($sformatf("rst.d%0d.valid", i), bus.DMA_VALID, 1'b0);
        end
        drive(0, 1, 0, 16'h4000, 8'h00, 16'h0200, 0, 8'h00);
        chk("rst.d8.hold", bus.HOLD, 1'b0);
        chk("rst.d8.ack", bus.DMA_ACK, 1'b1);
        chk("rst.d8.mem_a", bus.MEM_A, 16'h4000);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h0200, 0, 8'h00);
        chk("rst.d9.valid", bus.DMA_VALID, 1'b1);
        chk("rst.d9.rdata", bus.DMA_RDATA, 8'h11);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h0200, 0, 8'h00);
        chk("rst.d10.hold", bus.HOLD, 1'b0);
        chk("rst.d10.valid", bus.DMA_VALID, 1'b0);
        drive(0, 0, 0, 16'h0000, 8'h00, 16'h0200, 0, 8'h00);
        chk("rst.d11.hold", bus.HOLD, 1'b1);
        chk("rst.ram5000", mem[16'h5000], 8'hE1);
        chk("rst.ram5001", mem[16'h5001], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/z80_bus_arbiter.md
# z80_bus_arbiter

Shares the single synchronous RAM port between the `z80` core and one DMA requester (loader, video fetch). It stalls the core through `HOLD`, grants bounded DMA bursts, and re-issues the core's frozen address before resuming. This keeps the core's one-cycle read pipeline coherent. It sits between `z80` (A/DI/DO/W/HOLD) and the RAM.

## Interface
- `MAX_BURST`, 16: max accepted DMA transfers per grant, ≥1.
- `CPU_MIN`, 4: min CPU cycles per CPU window before the next grant; effective minimum is max(CPU_MIN,1).
- `CLOCK` in 1: single clock, rising edge.
- `RESET` in 1: synchronous, active-high.
- `CPU_A` in 16: core address.
- `CPU_DO` in 8: core write data.
- `CPU_W` in 1: core write strobe.
- `CPU_DI` out 8: read data to the core; equals `MEM_Q`, combinational.
- `HOLD` out 1: registered; 1 = core runs, 0 = core frozen.
- `DMA_REQ` in 1: DMA request; held with `DMA_ADDR`/`DMA_WE`/`DMA_WDATA` stable until `DMA_ACK`.
- `DMA_WE` in 1: 1 = write, 0 = read.
- `DMA_ADDR` in 16: DMA address.
- `DMA_WDATA` in 8: DMA write data.
- `DMA_ACK` out 1: combinational; `(state==DMA) & DMA_REQ`; transfer happens on this edge.
- `DMA_RDATA` out 8: equals `MEM_Q`.
- `DMA_VALID` out 1: registered; 1 in the cycle after an accepted read.
- `MEM_A` out 16, `MEM_D` out 8, `MEM_W` out 1: RAM address, write data, write enable.
- `MEM_Q` in 8: RAM read data; registered RAM, `MEM_Q(n+1) = mem[MEM_A(n)]`.

## Operation
- States:
  - CPU: `HOLD`=1; `MEM_A`=`CPU_A`, `MEM_D`=`CPU_DO`, `MEM_W`=`CPU_W`.
  - DMA: `HOLD`=0; `MEM_A`=`DMA_ADDR`, `MEM_D`=`DMA_WDATA`, `MEM_W`=`DMA_ACK & DMA_WE`.
  - RESUME: `HOLD`=0; `MEM_A`=`CPU_A`, `MEM_W`=0. This is a re-fetch so `MEM_Q` is the core's data when `HOLD` rises.
- Counters:
  - `wcnt`: CPU cycles in the current window, saturating at max(CPU_MIN,1). Set to 1 on the first CPU cycle (the edge RESUME→CPU loads 0, and it increments each CPU cycle).
  - `bcnt`: accepted DMA transfers, width $clog2(MAX_BURST+1). Cleared on CPU→DMA.
- Transitions, evaluated at the rising edge:
  - CPU→DMA when `DMA_REQ`=1 and the current cycle is at least the max(CPU_MIN,1)-th cycle of the window; otherwise stay in CPU.
  - DMA→RESUME when `DMA_REQ`=0, or when this cycle's accept makes `bcnt`=MAX_BURST.
  - RESUME→CPU always.
- A core write in the last CPU cycle before a grant completes: `MEM_W`=`CPU_W` in that cycle, and the core consumes it because `HOLD`=1.
- A core write pending while frozen (core holds `W`=1) is performed in the first CPU cycle after RESUME, never in RESUME.
- DMA read data is presented on `MEM_Q` in the next cycle with `DMA_VALID`=1. This includes the RESUME cycle when the last accepted transfer was a read.
- `DMA_REQ` dropping without an ack is legal; the arbiter returns to the CPU.
- `CPU_DI` is meaningful only when `HOLD`=1.

## Timing
- Reset:
  - state=RESUME, `wcnt`=0, `bcnt`=0.
  - `HOLD`=0, `DMA_VALID`=0, `DMA_ACK`=0, `MEM_W`=0.
  - The first CPU cycle (`HOLD`=1) is the 2nd cycle after `RESET` deasserts.
- Reset mid-burst aborts the grant: no `MEM_W` in the reset cycle, no `DMA_VALID` afterwards.
- Grant latency: `DMA_REQ` high in an eligible CPU cycle t → `HOLD`=0 and `DMA_ACK`=1 at t+1. A read accepted at t+1 gives `DMA_VALID` at t+2.
- Back-to-back transfers: one per cycle while `DMA_REQ`=1, up to MAX_BURST per grant.
- Release:
  - Last accept at cycle k (bcnt limit) → RESUME at k+1 → CPU (`HOLD`=1) at k+2.
  - Same timing when `DMA_REQ`=0 at cycle k.
- Min core service between grants: max(CPU_MIN,1) CPU cycles. A continuously requesting DMA gets MAX_BURST of every MAX_BURST+1+max(CPU_MIN,1) cycles.
- Simultaneous: `DMA_REQ` rising in the same cycle as `CPU_W`=1 → the CPU write goes to RAM that cycle, and the grant takes effect next cycle.

## Test plan
- Reset then idle (`DMA_REQ`=0):
  - `HOLD`=0 for 1 cycle after reset release, then 1 permanently.
  - `MEM_A` tracks `CPU_A`; no DMA signals toggle.
- DMA read burst of 3 from 0x4000 (mem=0x11,0x22,0x33), CPU_MIN=4, DMA_REQ after 10 CPU cycles:
  - `HOLD` falls next cycle; `DMA_ACK` for 3 cycles.
  - `DMA_VALID` with 0x11/0x22/0x33 on the following cycles.
  - RESUME drives `MEM_A`=`CPU_A`; `HOLD`=1 two cycles after the last ack.
- Continuous DMA writes, MAX_BURST=16, CPU_MIN=4:
  - Exactly 16 acks, 1 RESUME, 4 CPU cycles, repeating.
  - RAM holds all written bytes; the core executes 4 cycles per window.
- Core `LD (0x8000),HL` with DMA_REQ arriving between its two writes:
  - RAM 0x8000=L, 0x8001=H.
  - The second write happens only in the first CPU cycle after RESUME.
- Frozen core fetch at 0x0100 (mem=0x3E), DMA writes 0x0100←0x55 during the stall:
  - After resume, `CPU_DI`=0x55 when `HOLD` rises (re-fetch is coherent).
- `RESET` asserted on the 2nd cycle of a DMA burst:
  - No further `DMA_ACK`/`DMA_VALID`; `MEM_W`=0.
  - Recovery identical to the first scenario.
